// File: rtl/screen_pkg.sv
// Shared types and default geometry for the text-mode screen buffer.
package screen_pkg;

    localparam int unsigned DEF_COLS   = 80;
    localparam int unsigned DEF_ROWS   = 60;
    localparam int unsigned DEF_CHAR_W = 8;
    localparam int unsigned DEF_ATTR_W = 8;

    typedef enum logic [1:0] {
        CMD_WRITE  = 2'd0,
        CMD_CLEAR  = 2'd1,
        CMD_SCROLL = 2'd2,
        CMD_NOP    = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        SCR  = 2'd2
    } state_e;

    typedef struct packed {
        logic [DEF_ATTR_W-1:0] attr;
        logic [DEF_CHAR_W-1:0] chr;
    } cell_t;

endpackage

// File: rtl/screen_ram_sdp.sv
// Simple dual-port cell RAM: one write port, one registered read-first read port.
module screen_ram_sdp #(
    parameter int unsigned DEPTH  = 4800,
    parameter int unsigned CELL_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [$clog2(DEPTH)-1:0]  waddr,
    input  logic [CELL_W-1:0]         wdata,
    input  logic                      re,
    input  logic [$clog2(DEPTH)-1:0]  raddr,
    output logic [CELL_W-1:0]         rdata
);

    logic [CELL_W-1:0] mem_q [DEPTH];
    logic [CELL_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Both ports sample on the same edge, so a colliding read sees the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/screen_buffer_sdp.sv
// Text-mode screen buffer with host write port, video read port and
// hardware clear / circular-offset scroll engine.
module screen_buffer_sdp
    import screen_pkg::*;
#(
    parameter int unsigned COLS   = DEF_COLS,
    parameter int unsigned ROWS   = DEF_ROWS,
    parameter int unsigned CHAR_W = DEF_CHAR_W,
    parameter int unsigned ATTR_W = DEF_ATTR_W,
    parameter logic [CHAR_W+ATTR_W-1:0] FILL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         host_valid,
    output logic                         host_ready,
    input  logic [1:0]                   host_cmd,
    input  logic [$clog2(COLS)-1:0]      host_col,
    input  logic [$clog2(ROWS)-1:0]      host_row,
    input  logic [CHAR_W+ATTR_W-1:0]     host_data,
    output logic                         host_err,
    output logic                         busy,
    output logic [$clog2(ROWS)-1:0]      top_row,
    input  logic                         vid_en,
    input  logic [$clog2(COLS)-1:0]      vid_col,
    input  logic [$clog2(ROWS)-1:0]      vid_row,
    output logic [CHAR_W+ATTR_W-1:0]     vid_data,
    output logic                         vid_valid
);

    localparam int unsigned CELL_W = CHAR_W + ATTR_W;
    localparam int unsigned DEPTH  = COLS * ROWS;
    localparam int unsigned CW     = $clog2(COLS);
    localparam int unsigned RW     = $clog2(ROWS);
    localparam int unsigned AW     = $clog2(DEPTH);

    function automatic logic col_ok(input logic [CW-1:0] col);
        return (CW+1)'(col) < (CW+1)'(COLS);
    endfunction

    function automatic logic row_ok(input logic [RW-1:0] row);
        return (RW+1)'(row) < (RW+1)'(ROWS);
    endfunction

    // Logical (col,row) to RAM address via the circular row offset; no divider.
    function automatic logic [AW-1:0] map_addr(input logic [CW-1:0] col,
                                               input logic [RW-1:0] row,
                                               input logic [RW-1:0] top);
        logic [RW:0] sum;
        sum = (RW+1)'(row) + (RW+1)'(top);
        if (sum >= (RW+1)'(ROWS)) begin
            sum = sum - (RW+1)'(ROWS);
        end
        return AW'(sum) * AW'(COLS) + AW'(col);
    endfunction

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     top_row_q, top_row_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              host_err_q, host_err_d;
    logic              vid_valid_q, vid_valid_d;
    logic              vid_oob_q, vid_oob_d;

    logic              accept_c;
    logic              we_c;
    logic [AW-1:0]     waddr_c;
    logic [CELL_W-1:0] wdata_c;
    logic              re_c;
    logic [AW-1:0]     raddr_c;
    logic [CELL_W-1:0] ram_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            top_row_q   <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            host_err_q  <= 1'b0;
            vid_valid_q <= 1'b0;
            vid_oob_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            top_row_q   <= top_row_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            host_err_q  <= host_err_d;
            vid_valid_q <= vid_valid_d;
            vid_oob_q   <= vid_oob_d;
        end
    end

    // Command FSM, fill engine and write-port steering.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        top_row_d  = top_row_q;
        host_err_d = 1'b0;
        we_c       = 1'b0;
        waddr_c    = '0;
        wdata_c    = FILL;
        accept_c   = host_valid && ready_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    case (cmd_e'(host_cmd))
                        CMD_WRITE: begin
                            if (col_ok(host_col) && row_ok(host_row)) begin
                                we_c    = 1'b1;
                                waddr_c = map_addr(host_col, host_row, top_row_q);
                                wdata_c = host_data;
                            end else begin
                                host_err_d = 1'b1;
                            end
                        end
                        CMD_CLEAR: begin
                            state_d = CLR;
                            cnt_d   = '0;
                        end
                        CMD_SCROLL: begin
                            state_d = SCR;
                            cnt_d   = '0;
                        end
                        CMD_NOP: ;
                        default: ;
                    endcase
                end
            end
            CLR: begin
                we_c    = 1'b1;
                waddr_c = cnt_q;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    top_row_d = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            SCR: begin
                we_c    = 1'b1;
                waddr_c = AW'(top_row_q) * AW'(COLS) + cnt_q;
                if (cnt_q == AW'(COLS - 1)) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    top_row_d = (top_row_q == RW'(ROWS - 1)) ? '0 : top_row_q + RW'(1);
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // Video port: out-of-range requests skip the RAM and return zero.
    always_comb begin
        vid_valid_d = vid_en;
        vid_oob_d   = vid_oob_q;
        re_c        = 1'b0;
        raddr_c     = map_addr(vid_col, vid_row, top_row_q);
        if (vid_en) begin
            vid_oob_d = !(col_ok(vid_col) && row_ok(vid_row));
            re_c      = !vid_oob_d;
        end
    end

    screen_ram_sdp #(
        .DEPTH  (DEPTH),
        .CELL_W (CELL_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we_c),
        .waddr (waddr_c),
        .wdata (wdata_c),
        .re    (re_c),
        .raddr (raddr_c),
        .rdata (ram_rdata)
    );

    assign host_ready = ready_q;
    assign busy       = busy_q;
    assign host_err   = host_err_q;
    assign top_row    = top_row_q;
    assign vid_valid  = vid_valid_q;
    assign vid_data   = vid_oob_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_screen_buffer_sdp.sv
// Self-checking bench for screen_buffer_sdp against a logical-screen reference model.
module tb_screen_buffer_sdp;
    import screen_pkg::*;

    localparam int COLS  = 80;
    localparam int ROWS  = 60;
    localparam int DEPTH = COLS * ROWS;
    localparam logic [15:0] FILL = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_valid = 1'b0;
    logic        host_ready;
    logic [1:0]  host_cmd = 2'd0;
    logic [6:0]  host_col = '0;
    logic [5:0]  host_row = '0;
    logic [15:0] host_data = '0;
    logic        host_err;
    logic        busy;
    logic [5:0]  top_row;
    logic        vid_en = 1'b0;
    logic [6:0]  vid_col = '0;
    logic [5:0]  vid_row = '0;
    logic [15:0] vid_data;
    logic        vid_valid;

    logic [15:0] model [DEPTH];
    bit          known [DEPTH];
    int          top_m;
    int          n_checks;
    int          n_fail;

    always #5 clk = ~clk;

    screen_buffer_sdp #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .CHAR_W (8),
        .ATTR_W (8),
        .FILL   (FILL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_cmd   (host_cmd),
        .host_col   (host_col),
        .host_row   (host_row),
        .host_data  (host_data),
        .host_err   (host_err),
        .busy       (busy),
        .top_row    (top_row),
        .vid_en     (vid_en),
        .vid_col    (vid_col),
        .vid_row    (vid_row),
        .vid_data   (vid_data),
        .vid_valid  (vid_valid)
    );

    function automatic int paddr(input int col, input int row);
        return ((row + top_m) % ROWS) * COLS + col;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int col, input int row, input logic [15:0] data);
        host_valid = 1'b1;
        host_cmd   = 2'd0;
        host_col   = 7'(col);
        host_row   = 6'(row);
        host_data  = data;
        tick();
        host_valid = 1'b0;
        if (col < COLS && row < ROWS) begin
            model[paddr(col, row)] = data;
            known[paddr(col, row)] = 1'b1;
        end
    endtask

    task automatic issue(input logic [1:0] cmd);
        host_valid = 1'b1;
        host_cmd   = cmd;
        tick();
        host_valid = 1'b0;
    endtask

    task automatic model_scroll();
        for (int c = 0; c < COLS; c++) begin
            model[top_m * COLS + c] = FILL;
            known[top_m * COLS + c] = 1'b1;
        end
        top_m = (top_m + 1) % ROWS;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        n_checks += 6;
        if (host_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", host_ready); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (host_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", host_err); end
        if (top_row !== 6'd0) begin n_fail++; $display("FAIL reset_top: got %0d expected 0", top_row); end
        if (vid_data !== 16'h0) begin n_fail++; $display("FAIL reset_vdata: got %h expected 0000", vid_data); end
        if (vid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vvalid: got %b expected 0", vid_valid); end
    endtask

    task automatic test_write_read();
        cell_t c;
        c.attr = 8'h1F;
        c.chr  = 8'h41;
        host_write(5, 2, c);
        n_checks += 2;
        if (host_err !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b expected 0", host_err); end
        if (host_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready: got %b expected 1", host_ready); end
        vid_en = 1'b1; vid_col = 7'd5; vid_row = 6'd2;
        tick();
        vid_en = 1'b0;
        n_checks += 2;
        if (vid_valid !== 1'b1) begin n_fail++; $display("FAIL rd_valid: got %b expected 1", vid_valid); end
        if (vid_data !== 16'h1F41) begin n_fail++; $display("FAIL rd_data: got %h expected 1f41", vid_data); end
        tick();
        n_checks += 2;
        if (vid_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_drop: got %b expected 0", vid_valid); end
        if (vid_data !== 16'h1F41) begin n_fail++; $display("FAIL rd_hold: got %h expected 1f41", vid_data); end
    endtask

    task automatic test_oob_write();
        host_write(0, 1, 16'h1234);
        host_write(80, 0, 16'hABCD);
        n_checks += 2;
        if (host_err !== 1'b1) begin n_fail++; $display("FAIL oob_err: got %b expected 1", host_err); end
        if (host_ready !== 1'b1) begin n_fail++; $display("FAIL oob_ready: got %b expected 1", host_ready); end
        vid_en = 1'b1; vid_col = 7'd0; vid_row = 6'd1;
        tick();
        vid_en = 1'b0;
        n_checks += 2;
        if (host_err !== 1'b0) begin n_fail++; $display("FAIL oob_pulse: got %b expected 0", host_err); end
        if (vid_data !== 16'h1234) begin n_fail++; $display("FAIL oob_ram: got %h expected 1234", vid_data); end
        host_write(3, 60, 16'h7777);
        n_checks++;
        if (host_err !== 1'b1) begin n_fail++; $display("FAIL oob_row_err: got %b expected 1", host_err); end
        vid_en = 1'b1; vid_col = 7'd90; vid_row = 6'd3;
        tick();
        vid_en = 1'b0;
        n_checks += 2;
        if (vid_valid !== 1'b1) begin n_fail++; $display("FAIL vid_oob_valid: got %b expected 1", vid_valid); end
        if (vid_data !== 16'h0) begin n_fail++; $display("FAIL vid_oob_data: got %h expected 0000", vid_data); end
    endtask

    task automatic test_collision();
        host_write(10, 10, 16'hAAAA);
        host_valid = 1'b1; host_cmd = 2'd0; host_col = 7'd10; host_row = 6'd10; host_data = 16'hBBBB;
        vid_en = 1'b1; vid_col = 7'd10; vid_row = 6'd10;
        tick();
        host_valid = 1'b0;
        model[paddr(10, 10)] = 16'hBBBB;
        n_checks++;
        if (vid_data !== 16'hAAAA) begin n_fail++; $display("FAIL coll_old: got %h expected aaaa", vid_data); end
        tick();
        vid_en = 1'b0;
        n_checks++;
        if (vid_data !== 16'hBBBB) begin n_fail++; $display("FAIL coll_new: got %h expected bbbb", vid_data); end
    endtask

    task automatic test_scroll();
        int cnt;
        logic [15:0] exp;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                host_write(c, r, {8'h07, 8'(r)});
        issue(2'd2);
        cnt = 0;
        n_checks++;
        if (top_row !== 6'd0) begin n_fail++; $display("FAIL scr_top_early: got %0d expected 0", top_row); end
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            tick();
        end
        model_scroll();
        n_checks += 3;
        if (cnt !== COLS) begin n_fail++; $display("FAIL scr_cycles: got %0d expected %0d", cnt, COLS); end
        if (top_row !== 6'd1) begin n_fail++; $display("FAIL scr_top: got %0d expected 1", top_row); end
        if (host_ready !== 1'b1) begin n_fail++; $display("FAIL scr_ready: got %b expected 1", host_ready); end
        vid_en = 1'b1; vid_col = 7'd0; vid_row = 6'd0; tick();
        n_checks++;
        if (vid_data !== 16'h0701) begin n_fail++; $display("FAIL scr_row0: got %h expected 0701", vid_data); end
        vid_col = 7'd5; vid_row = 6'd58; tick();
        n_checks++;
        if (vid_data !== 16'h073B) begin n_fail++; $display("FAIL scr_row58: got %h expected 073b", vid_data); end
        vid_col = 7'd7; vid_row = 6'd59; tick();
        n_checks++;
        if (vid_data !== FILL) begin n_fail++; $display("FAIL scr_row59: got %h expected %h", vid_data, FILL); end
        for (int i = 0; i < DEPTH; i++) begin
            vid_col = 7'(i % COLS); vid_row = 6'(i / COLS);
            tick();
            exp = model[paddr(i % COLS, i / COLS)];
            n_checks++;
            if (vid_data !== exp) begin
                n_fail++;
                $display("FAIL scr_sweep (%0d,%0d): got %h expected %h", i % COLS, i / COLS, vid_data, exp);
            end
        end
        vid_en = 1'b0;
        for (int s = 0; s < ROWS; s++) begin
            issue(2'd2);
            cnt = 0;
            while (busy === 1'b1 && cnt < 200) begin
                cnt++;
                tick();
            end
            model_scroll();
            n_checks++;
            if (cnt !== COLS) begin n_fail++; $display("FAIL scr_multi_cycles: got %0d expected %0d", cnt, COLS); end
        end
        n_checks++;
        if (top_row !== 6'(top_m) || top_m != 1) begin
            n_fail++; $display("FAIL scr_wrap: got %0d expected 1", top_row);
        end
    endtask

    task automatic test_random();
        logic [15:0] vexp;
        bit vknown, err_exp;
        int hc, hr, vc, vr, a;
        vknown = 1'b0;
        vexp = '0;
        for (int i = 0; i < 500; i++) begin
            host_valid = ($urandom_range(0, 3) != 0);
            host_cmd   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'd0;
            hc = $urandom_range(0, 83); hr = $urandom_range(0, 62);
            host_col = 7'(hc); host_row = 6'(hr); host_data = 16'($urandom);
            vid_en = 1'($urandom_range(0, 1));
            vc = $urandom_range(0, 85); vr = $urandom_range(0, 63);
            vid_col = 7'(vc); vid_row = 6'(vr);
            if (vid_en) begin
                if (vc >= COLS || vr >= ROWS) begin
                    vexp = '0; vknown = 1'b1;
                end else begin
                    a = paddr(vc, vr); vexp = model[a]; vknown = known[a];
                end
            end
            err_exp = host_valid && host_cmd == 2'd0 && (hc >= COLS || hr >= ROWS);
            if (host_valid && host_cmd == 2'd0 && !err_exp) begin
                a = paddr(hc, hr); model[a] = host_data; known[a] = 1'b1;
            end
            tick();
            n_checks += 4;
            if (host_err !== err_exp) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b expected %b", i, host_err, err_exp); end
            if (vid_valid !== vid_en) begin n_fail++; $display("FAIL rnd_vvalid[%0d]: got %b expected %b", i, vid_valid, vid_en); end
            if (host_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rnd_idle[%0d]: ready %b busy %b expected 1 0", i, host_ready, busy); end
            if (top_row !== 6'(top_m)) begin n_fail++; $display("FAIL rnd_top[%0d]: got %0d expected %0d", i, top_row, top_m); end
            if (vknown) begin
                n_checks++;
                if (vid_data !== vexp) begin n_fail++; $display("FAIL rnd_vdata[%0d]: got %h expected %h", i, vid_data, vexp); end
            end
        end
        host_valid = 1'b0;
        vid_en = 1'b0;
    endtask

    task automatic test_clear();
        int cnt, low;
        issue(2'd1);
        cnt = 0; low = 0;
        while (busy === 1'b1 && cnt < 6000) begin
            cnt++;
            if (host_ready === 1'b0) low++;
            tick();
        end
        for (int i = 0; i < DEPTH; i++) begin model[i] = FILL; known[i] = 1'b1; end
        top_m = 0;
        n_checks += 4;
        if (cnt !== DEPTH) begin n_fail++; $display("FAIL clr_busy_cycles: got %0d expected %0d", cnt, DEPTH); end
        if (low !== DEPTH) begin n_fail++; $display("FAIL clr_ready_low: got %0d expected %0d", low, DEPTH); end
        if (host_ready !== 1'b1) begin n_fail++; $display("FAIL clr_ready: got %b expected 1", host_ready); end
        if (top_row !== 6'd0) begin n_fail++; $display("FAIL clr_top: got %0d expected 0", top_row); end
        vid_en = 1'b1; vid_col = 7'd0; vid_row = 6'd0; tick();
        n_checks++;
        if (vid_data !== FILL) begin n_fail++; $display("FAIL clr_first: got %h expected %h", vid_data, FILL); end
        vid_col = 7'd79; vid_row = 6'd59; tick();
        n_checks++;
        if (vid_data !== FILL) begin n_fail++; $display("FAIL clr_last: got %h expected %h", vid_data, FILL); end
        vid_col = 7'd40; vid_row = 6'd30; tick();
        vid_en = 1'b0;
        n_checks++;
        if (vid_data !== FILL) begin n_fail++; $display("FAIL clr_mid: got %h expected %h", vid_data, FILL); end
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        issue(2'd2);
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin cnt++; tick(); end
        model_scroll();
        n_checks++;
        if (top_row !== 6'(top_m)) begin n_fail++; $display("FAIL rmc_pre_top: got %0d expected %0d", top_row, top_m); end
        issue(2'd1);
        repeat (99) tick();
        n_checks += 2;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rmc_busy_pre: got %b expected 1", busy); end
        if (host_ready !== 1'b0) begin n_fail++; $display("FAIL rmc_ready_pre: got %b expected 0", host_ready); end
        rst_n = 1'b0;
        #1;
        n_checks += 4;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rmc_busy: got %b expected 0", busy); end
        if (host_ready !== 1'b1) begin n_fail++; $display("FAIL rmc_ready: got %b expected 1", host_ready); end
        if (top_row !== 6'd0) begin n_fail++; $display("FAIL rmc_top: got %0d expected 0", top_row); end
        if (vid_valid !== 1'b0) begin n_fail++; $display("FAIL rmc_vvalid: got %b expected 0", vid_valid); end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        top_m = 0;
        tick();
        host_write(3, 3, 16'h5A5A);
        n_checks++;
        if (host_err !== 1'b0) begin n_fail++; $display("FAIL rmc_wr_err: got %b expected 0", host_err); end
        vid_en = 1'b1; vid_col = 7'd3; vid_row = 6'd3; tick();
        vid_en = 1'b0;
        n_checks++;
        if (vid_data !== 16'h5A5A) begin n_fail++; $display("FAIL rmc_rd: got %h expected 5a5a", vid_data); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        top_m    = 0;
        for (int i = 0; i < DEPTH; i++) begin model[i] = '0; known[i] = 1'b0; end
        test_reset();
        test_write_read();
        test_oob_write();
        test_collision();
        test_scroll();
        test_random();
        test_clear();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
